// File: rtl/obj_cmd_pkg.sv
// Shared types and constants for the object command path: address range,
// the serializer command word layout and the transfer sequencer states.
package obj_cmd_pkg;

  localparam int ADDR_W  = 5;
  localparam int NUM_OBJ = 18;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cmd;
  } cmd_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/obj_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request found when
// scanning upward from rr_ptr, wrapping at N. The pointer lives in the parent.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    winner   = '0;
    win_idx  = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        winner[cand_idx] = 1'b1;
        win_idx         = cand_idx;
      end
    end
  end

endmodule

// File: rtl/obj_cmd_arbiter.sv
// Shares the serializer command path between NUM_REQ requesters: round-robin
// grant, address range check, and one issue per serializer busy cycle.
module obj_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = obj_cmd_pkg::ADDR_W,
  parameter int NUM_OBJ = obj_cmd_pkg::NUM_OBJ,
  parameter int BUSY_TO = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]             req_cmd_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [ADDR_W:0]                data_o,
  output logic                           data_val_o,
  input  logic                           busy_i,
  output logic                           err_o,
  output logic                           timeout_o
);

  import obj_cmd_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TO + 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [ADDR_W:0]    data_q, data_n;
  logic               val_q, val_n;
  logic               err_q, err_n;
  logic               to_q, to_n;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [ADDR_W-1:0]  win_addr;
  logic               addr_ok;
  logic               arb_fire;
  logic               busy_expired;
  cmd_word_t          win_word;

  // A requester may still hold req_i during its own grant cycle, so it is
  // masked for that one evaluation to avoid consuming the same request twice.
  assign arb_req = req_i & ~gnt_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req     (arb_req),
    .rr_ptr  (rr_ptr_q),
    .winner  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  assign win_addr      = req_addr_i[win_idx];
  assign addr_ok       = (win_addr != '0) && (int'(win_addr) <= NUM_OBJ);
  assign arb_fire      = (state_q == IDLE) && !busy_i && win_any;
  assign busy_expired  = (state_q == WAIT_BUSY) && !busy_i && (cnt_q == CNT_LAST);
  assign win_word.addr = win_addr;
  assign win_word.cmd  = req_cmd_i[win_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      data_q   <= '0;
      val_q    <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      cnt_q    <= cnt_n;
      gnt_q    <= gnt_n;
      data_q   <= data_n;
      val_q    <= val_n;
      err_q    <= err_n;
      to_q     <= to_n;
    end
  end

  // Rejected addresses still advance the pointer but never leave IDLE.
  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    cnt_n    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_fire) begin
          rr_ptr_n = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
          if (addr_ok) state_n = ISSUE;
        end
      end
      ISSUE: begin
        state_n = WAIT_BUSY;
        cnt_n   = '0;
      end
      WAIT_BUSY: begin
        if (busy_i) begin
          state_n = WAIT_DONE;
        end else if (busy_expired) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n  = '0;
    data_n = data_q;
    val_n  = 1'b0;
    err_n  = 1'b0;
    to_n   = busy_expired;
    if (arb_fire) begin
      gnt_n = win_oh;
      if (addr_ok) begin
        data_n = win_word;
        val_n  = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign data_o     = data_q;
  assign data_val_o = val_q;
  assign err_o      = err_q;
  assign timeout_o  = to_q;

endmodule

// File: tb/tb_obj_cmd_arbiter.sv
// Bench for obj_cmd_arbiter: cycle table, directed corner sequences and a
// randomized run, all compared every cycle against a transaction-level model.
module tb_obj_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int NUM_OBJ = 18;
  localparam int BUSY_TO = 15;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [NUM_REQ-1:0]             req_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]             req_cmd_i;
  logic [NUM_REQ-1:0]             gnt_o;
  logic [ADDR_W:0]                data_o;
  logic                           data_val_o;
  logic                           busy_i;
  logic                           err_o;
  logic                           timeout_o;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: a transfer is tracked by edges since issue and whether
  // busy has been seen, rather than by any state encoding.
  int                 m_ptr  = 0;
  int                 m_t    = 0;
  bit                 m_xfer = 1'b0;
  bit                 m_seen = 1'b0;
  logic [NUM_REQ-1:0] m_gnt  = '0;
  logic               m_val  = 1'b0;
  logic               m_err  = 1'b0;
  logic               m_to   = 1'b0;
  logic [ADDR_W:0]    m_data = '0;

  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic [19:0] addr;
    logic [3:0]  cmd;
    logic        busy;
    logic [3:0]  gnt;
    logic        val;
    logic        err;
    logic        to;
    logic [5:0]  data;
  } vec_t;

  obj_cmd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .NUM_OBJ (NUM_OBJ),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .req_cmd_i  (req_cmd_i),
    .gnt_o      (gnt_o),
    .data_o     (data_o),
    .data_val_o (data_val_o),
    .busy_i     (busy_i),
    .err_o      (err_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] dut_word();
    return {19'd0, gnt_o, data_val_o, err_o, timeout_o, data_o};
  endfunction

  function automatic logic [31:0] model_word();
    return {19'd0, m_gnt, m_val, m_err, m_to, m_data};
  endfunction

  task automatic applyStimulus(input logic rstn, input logic [3:0] req,
                               input logic [19:0] addr, input logic [3:0] cmd,
                               input logic busy);
    rst_i      = rstn;
    req_i      = req;
    req_addr_i = addr;
    req_cmd_i  = cmd;
    busy_i     = busy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelStep();
    logic [NUM_REQ-1:0] prev;
    int w;
    bit found;
    prev  = m_gnt;
    m_gnt = '0;
    m_val = 1'b0;
    m_err = 1'b0;
    m_to  = 1'b0;
    found = 1'b0;
    if (!rst_i) begin
      m_ptr  = 0;
      m_xfer = 1'b0;
      m_data = '0;
    end else if (!m_xfer) begin
      if (!busy_i) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w = (m_ptr + k) % NUM_REQ;
          if (!found && req_i[w] && !prev[w]) begin
            found    = 1'b1;
            m_gnt[w] = 1'b1;
            m_ptr    = (w + 1) % NUM_REQ;
            if (req_addr_i[w] >= 1 && req_addr_i[w] <= NUM_OBJ) begin
              m_val  = 1'b1;
              m_data = {req_addr_i[w], req_cmd_i[w]};
              m_xfer = 1'b1;
              m_t    = 0;
              m_seen = 1'b0;
            end else begin
              m_err = 1'b1;
            end
          end
        end
      end
    end else begin
      m_t++;
      if (m_t > 1) begin
        if (!m_seen) begin
          if (busy_i) m_seen = 1'b1;
          else if (m_t == BUSY_TO + 1) begin
            m_to   = 1'b1;
            m_xfer = 1'b0;
          end
        end else if (!busy_i) begin
          m_xfer = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    modelStep();
    @(negedge clk_i);
    cyc++;
    checkOutput("model", dut_word(), model_word());
  endtask

  initial begin
    vec_t               tbl[19];
    logic [19:0]        a0, a19;
    logic [3:0]         cmd_rand;
    logic [NUM_REQ-1:0] nreq;
    logic [19:0]        naddr;
    logic [3:0]         ncmd;
    logic               nbusy, nrst;
    int                 n_g, ser, v0, v1, tc, nto, sel, ser_wait, ser_len;
    int                 g_idx[4];
    logic [5:0]         g_data[4];

    // Single issue with an 8-cycle busy, then two rejected addresses and a
    // valid request at the top of the range.
    a0  = {5'd18, 5'd0, 5'd0, 5'd7};
    a19 = {5'd18, 5'd19, 5'd0, 5'd7};
    tbl[0]  = '{1'b0, 4'b0000, a0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[1]  = '{1'b1, 4'b0001, a0, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 6'b001111};
    tbl[2]  = '{1'b1, 4'b0000, a0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b001111};
    for (int i = 3; i <= 10; i++)
      tbl[i] = '{1'b1, 4'b0000, a0, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b001111};
    tbl[11] = '{1'b1, 4'b0000, a0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b001111};
    tbl[12] = '{1'b1, 4'b0100, a0, 4'b1001, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[13] = '{1'b1, 4'b0100, a0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b001111};
    tbl[14] = '{1'b1, 4'b0100, a19, 4'b1001, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[15] = '{1'b1, 4'b1000, a19, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 6'b100101};
    tbl[16] = '{1'b1, 4'b0000, a19, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b100101};
    tbl[17] = '{1'b1, 4'b0000, a19, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b100101};
    tbl[18] = '{1'b1, 4'b0000, a19, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b100101};

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].rstn, tbl[i].req, tbl[i].addr, tbl[i].cmd, tbl[i].busy);
      tick();
      checkOutput($sformatf("table[%0d]", i), dut_word(),
                  {19'd0, tbl[i].gnt, tbl[i].val, tbl[i].err, tbl[i].to, tbl[i].data});
    end

    // All four requesting with a 6-cycle serializer: strict rotation from 0.
    cmd_rand = 4'($urandom);
    applyStimulus(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, cmd_rand, 1'b0);
    n_g = 0;
    ser = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      nreq = req_i;
      if (gnt_o != '0) begin
        if (n_g < 4) begin
          for (int k = 0; k < NUM_REQ; k++) if (gnt_o[k]) g_idx[n_g] = k;
          g_data[n_g] = data_o;
        end
        n_g++;
        nreq = nreq & ~gnt_o;
      end
      if (data_val_o) ser = 6;
      nbusy = (ser > 0);
      if (ser > 0) ser--;
      applyStimulus(1'b1, nreq, req_addr_i, req_cmd_i, nbusy);
    end
    checkOutput("p2_grant_count", n_g, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("p2_order%0d", k), g_idx[k], k);
      checkOutput($sformatf("p2_data%0d", k), 32'(g_data[k]), 32'({5'(k + 1), cmd_rand[k]}));
    end

    // Serializer never answers the first issue: timeout, then the next grant.
    applyStimulus(1'b1, 4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, 4'b0010, 1'b0);
    v0 = -1; v1 = -1; tc = -1; nto = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      nreq = req_i & ~gnt_o;
      if (data_val_o) begin
        if (v0 < 0) v0 = cyc;
        else if (v1 < 0) v1 = cyc;
      end
      if (timeout_o) begin
        nto++;
        if (tc < 0) tc = cyc;
      end
      nbusy = (v1 >= 0) && (cyc - v1 < 3);
      applyStimulus(1'b1, nreq, req_addr_i, req_cmd_i, nbusy);
    end
    checkOutput("p4_timeout_count", nto, 1);
    checkOutput("p4_timeout_delay", tc - v0, 16);
    checkOutput("p4_next_issue", v1 - tc, 1);

    // Busy from elsewhere holds off the grant until it falls.
    applyStimulus(1'b1, 4'b1000, {5'd9, 15'd0}, 4'b0000, 1'b1);
    for (int t = 0; t < 5; t++) begin
      tick();
      checkOutput("p5_gated", {gnt_o, data_val_o}, 5'b0);
    end
    applyStimulus(1'b1, 4'b1000, {5'd9, 15'd0}, 4'b0000, 1'b0);
    tick();
    checkOutput("p5_grant", {gnt_o, data_val_o}, 5'b10001);
    applyStimulus(1'b1, 4'b0000, {5'd9, 15'd0}, 4'b0000, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0000, {5'd9, 15'd0}, 4'b0000, 1'b0);
    tick();
    tick();

    // Reset in WAIT_DONE: outputs clear and the pointer restarts at 0.
    applyStimulus(1'b1, 4'b0010, {5'd0, 5'd0, 5'd10, 5'd0}, 4'b0000, 1'b0);
    tick();
    checkOutput("p6_setup_gnt", gnt_o, 4'b0010);
    applyStimulus(1'b1, 4'b0000, {5'd0, 5'd0, 5'd10, 5'd0}, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 4'b0110, {5'd0, 5'd12, 5'd11, 5'd0}, 4'b0110, 1'b0);
    tick();
    checkOutput("p6_reset_outputs", dut_word(), 32'd0);
    applyStimulus(1'b1, 4'b0110, {5'd0, 5'd12, 5'd11, 5'd0}, 4'b0110, 1'b0);
    tick();
    checkOutput("p6_first_gnt", {gnt_o, data_val_o, data_o}, {4'b0010, 1'b1, 5'd11, 1'b1});

    // Random requesters, serializer latency/length, silent serializer,
    // spontaneous busy and occasional reset.
    ser_wait = 0;
    ser_len  = 0;
    for (int t = 0; t < 3000; t++) begin
      nreq  = req_i;
      naddr = req_addr_i;
      ncmd  = req_cmd_i;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt_o[k]) begin
          nreq[k] = 1'b0;
        end else if (!nreq[k] && $urandom_range(0, 3) == 0) begin
          nreq[k] = 1'b1;
          sel = $urandom_range(0, 9);
          if (sel == 0) naddr[k*5 +: 5] = 5'd0;
          else if (sel == 1) naddr[k*5 +: 5] = 5'($urandom_range(19, 31));
          else naddr[k*5 +: 5] = 5'($urandom_range(1, 18));
          ncmd[k] = 1'($urandom);
        end
      end
      if (data_val_o) begin
        if ($urandom_range(0, 7) == 0) begin
          ser_wait = 0;
          ser_len  = 0;
        end else begin
          ser_wait = $urandom_range(0, 4);
          ser_len  = $urandom_range(1, 8);
        end
      end
      if (ser_wait > 0) begin
        ser_wait--;
        nbusy = 1'b0;
      end else if (ser_len > 0) begin
        nbusy = 1'b1;
        ser_len--;
      end else begin
        nbusy = 1'b0;
        if ($urandom_range(0, 40) == 0) ser_len = $urandom_range(1, 4);
      end
      nrst = ($urandom_range(0, 299) != 0);
      applyStimulus(nrst, nreq, naddr, ncmd, nbusy);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/obj_cmd_arbiter.md
Name: obj_cmd_arbiter

Overview:
Shares the single serializer → deserializer → object command path between NUM_REQ independent requesters. Each requester posts a 5-bit object address and a 1-bit command. The block arbitrates round-robin, rejects out-of-range addresses, and presents one command word at a time on the serializer's data/valid inputs. It sequences each transfer against the serializer's busy flag. It sits in the clk_1 domain, directly upstream of the serializer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, object address width
NUM_OBJ, 18, highest valid object address; valid range is 1..NUM_OBJ
BUSY_TO, 15, cycles to wait for busy_i to rise after issue before declaring a timeout

Ports:
clk_i  in  1  clock (serializer clock domain)
rst_i  in  1  synchronous, active-low reset
req_i  in  NUM_REQ  per-requester request level
req_addr_i  in  NUM_REQ x ADDR_W  per-requester object address
req_cmd_i  in  NUM_REQ  per-requester command bit
gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: request consumed
data_o  out  ADDR_W+1  command word {addr, cmd} to serializer data input
data_val_o  out  1  one-cycle valid pulse to serializer
busy_i  in  1  serializer busy
err_o  out  1  one-cycle pulse: granted request had an invalid address
timeout_o  out  1  one-cycle pulse: busy_i never rose after issue

Behaviour:
- Reset (rst_i=0 at a clk_i edge) forces the following, regardless of state:
  - gnt_o=0, data_o=0, data_val_o=0, err_o=0, timeout_o=0.
  - State goes to IDLE, rr_ptr=0, timeout counter=0.
  - An in-flight transfer is abandoned with no grant, error or timeout pulse.
- Requester protocol:
  - req_i[k] is held high until gnt_o[k] pulses.
  - req_addr_i[k] and req_cmd_i[k] stay stable while req_i[k] is high.
  - req_i[k] may drop in the gnt cycle or later.
  - Requests that drop before their grant are never issued.
- Arbitration:
  - Round-robin search starts at index rr_ptr and wraps modulo NUM_REQ.
  - After any grant, rr_ptr = granted index + 1 (mod NUM_REQ).
  - The arbiter evaluates only in IDLE.
- State machine, with N the cycle in which IDLE sees at least one req_i high and busy_i=0:
  - IDLE:
    - If busy_i=1, stay in IDLE and grant nothing.
    - If the winner's address is in 1..NUM_OBJ: at edge N, register gnt_o[win]=1, data_o={addr,cmd}, data_val_o=1; go to ISSUE. Grant and valid are both high during cycle N+1.
    - If the winner's address is 0 or greater than NUM_OBJ: register gnt_o[win]=1 and err_o=1 with data_val_o=0; stay in IDLE. The next arbitration can occur at cycle N+1.
  - ISSUE (one cycle):
    - Clear gnt_o and data_val_o. data_o holds its value until the next issue.
    - Go to WAIT_BUSY and clear the counter.
  - WAIT_BUSY:
    - If busy_i=1, go to WAIT_DONE.
    - Otherwise increment the counter.
    - If the counter reaches BUSY_TO, pulse timeout_o for one cycle and return to IDLE.
  - WAIT_DONE:
    - Stay while busy_i=1.
    - When busy_i=0, go to IDLE. The next grant is registered at that edge at the earliest.
- Spacing and pulse width:
  - At most one data_val_o pulse per serializer transfer.
  - Consecutive issues are at least 4 cycles apart.
  - data_val_o never rises while busy_i=1 is sampled in IDLE.
  - gnt_o is one-hot or zero; err_o, timeout_o and data_val_o are single-cycle pulses.
- Simultaneous events:
  - With all requests pending, grants rotate in strict order from rr_ptr.
  - A request rising in the same cycle as a grant to another requester waits for the next IDLE evaluation.
- Word format: data_o[ADDR_W:1]=address, data_o[0]=command.

Decomposition:
- Shared package obj_cmd_pkg contains:
  - ADDR_W and NUM_OBJ constants;
  - packed struct cmd_word_t {addr[ADDR_W-1:0], cmd} (width ADDR_W+1);
  - state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}.
- One natural sub-module is rr_arbiter (parameter N):
  - inputs: req vector, rr_ptr;
  - outputs: one-hot winner, winner index, any.
  - It is purely combinational; rr_ptr is updated in the parent.

Test Plan:
1. Reset then single request: req_i=4'b0001, addr=7, cmd=1 → gnt_o=4'b0001 and data_val_o=1 in the same cycle, data_o=6'b00111_1. Busy held 8 cycles then drop → exactly one data_val_o pulse.
2. All four requesting, addrs 1,2,3,4, serializer model busy for 6 cycles per word → grant order 0,1,2,3. data_o sequence {1,c0},{2,c1},{3,c2},{4,c3}. No overlap with busy_i.
3. Invalid address: req 2 with addr=0, then addr=19 → gnt_o[2] and err_o pulse each time, data_val_o stays 0, state remains IDLE. Valid req 3 (addr 18) is granted in the following cycle.
4. Timeout: issue to addr 5 with busy_i held 0 → timeout_o pulses once BUSY_TO=15 cycles after ISSUE, back to IDLE. Next pending request is granted.
5. Busy gate: busy_i=1 from an external start while req_i=4'b1000 → no grant until busy_i falls. Grant arrives on the first IDLE edge with busy_i=0.
6. Mid-transfer reset: rst_i=0 for 1 cycle during WAIT_DONE → all outputs 0 next cycle, rr_ptr=0. Pending req_i=4'b0110 → requester 1 is granted first.
